// File: rtl/npu_data_ops_pkg.sv
// rtl/npu_data_ops_pkg.sv - shared state encoding, slice descriptor and index-width helper for the data_ops path
package npu_data_ops_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Descriptor fields sized for the widest configuration; instances use the low bits.
  typedef struct packed {
    logic [15:0] start_idx;
    logic [15:0] end_idx;
    logic [7:0]  stride;
    logic        rev;
  } slice_desc_t;

  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/slice_lane_select.sv
// rtl/slice_lane_select.sv - per-beat lane index generation, valid mask and element mux
module slice_lane_select
  import npu_data_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_LANES   = 64,
  parameter int OUT_LANES  = 16,
  parameter int STRIDE_W   = 4,
  parameter int IDX_W      = idx_width(IN_LANES)
) (
  input  logic [IN_LANES*DATA_WIDTH-1:0]  i_data,
  input  logic [IDX_W-1:0]                i_base,
  input  logic [IDX_W-1:0]                i_end,
  input  logic [STRIDE_W-1:0]             i_stride,
`ifdef SLICE_REVERSE_EN
  input  logic                            i_rev,
`endif
  output logic [OUT_LANES*DATA_WIDTH-1:0] o_data,
  output logic [OUT_LANES-1:0]            o_mask,
  output logic                            o_last,
  output logic [IDX_W-1:0]                o_next_base
);

  localparam int LOG_OUT = $clog2(OUT_LANES);
  // Wide enough that base + (OUT_LANES)*stride never wraps and a reverse walk can go negative.
  localparam int CW = IDX_W + LOG_OUT + STRIDE_W + 1;

  logic [DATA_WIDTH-1:0] w_elem [IN_LANES];
  logic signed [CW-1:0]  w_idx  [OUT_LANES];
  logic [OUT_LANES-1:0]  w_ok;
  logic signed [CW-1:0]  w_base;
  logic signed [CW-1:0]  w_end;
  logic signed [CW-1:0]  w_stride;
  logic signed [CW-1:0]  w_step;
  logic signed [CW-1:0]  w_next;

  assign w_base   = signed'(CW'(i_base));
  assign w_end    = signed'(CW'(i_end));
  assign w_stride = signed'(CW'(i_stride));
  assign w_step   = w_stride * signed'(CW'(OUT_LANES));

`ifdef SLICE_REVERSE_EN
  assign w_next = i_rev ? (w_base - w_step) : (w_base + w_step);
  assign o_last = i_rev ? (w_next < w_end) : (w_next > w_end);
`else
  assign w_next = w_base + w_step;
  assign o_last = (w_next > w_end);
`endif
  assign o_next_base = w_next[IDX_W-1:0];

  for (genvar i = 0; i < IN_LANES; i++) begin : g_elem
    assign w_elem[i] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
`ifdef SLICE_REVERSE_EN
    assign w_idx[j] = i_rev ? (w_base - signed'(CW'(j)) * w_stride)
                            : (w_base + signed'(CW'(j)) * w_stride);
    assign w_ok[j]  = i_rev ? ((w_idx[j] >= w_end) && !w_idx[j][CW-1])
                            : (w_idx[j] <= w_end);
`else
    assign w_idx[j] = w_base + signed'(CW'(j)) * w_stride;
    assign w_ok[j]  = (w_idx[j] <= w_end);
`endif
    assign o_mask[j] = w_ok[j];
    assign o_data[j*DATA_WIDTH +: DATA_WIDTH] = w_ok[j] ? w_elem[w_idx[j][IDX_W-1:0]] : '0;
  end

endmodule

// File: rtl/strided_slice_unit.sv
// rtl/strided_slice_unit.sv - strided vector slice streamer; reverse walk built only with SLICE_REVERSE_EN
module strided_slice_unit
  import npu_data_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_LANES   = 64,
  parameter int OUT_LANES  = 16,
  parameter int STRIDE_W   = 4,
  parameter int IDX_W      = idx_width(IN_LANES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [IN_LANES*DATA_WIDTH-1:0]  data_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic [IDX_W-1:0]                start_idx,
  input  logic [IDX_W-1:0]                end_idx,
  input  logic [STRIDE_W-1:0]             stride,
  input  logic                            dir_rev,
  output logic [OUT_LANES*DATA_WIDTH-1:0] data_out,
  output logic [OUT_LANES-1:0]            lane_mask,
  output logic                            valid_out,
  output logic                            last_out,
  input  logic                            ready_out,
  output logic                            cfg_err
);

  state_t r_state, w_state_nxt;

  logic [IN_LANES*DATA_WIDTH-1:0]  r_data;
  logic [IDX_W-1:0]                r_end;
  logic [STRIDE_W-1:0]             r_stride;
  logic [IDX_W-1:0]                r_next_base;
  logic [OUT_LANES*DATA_WIDTH-1:0] r_data_out;
  logic [OUT_LANES-1:0]            r_mask;
  logic                            r_valid;
  logic                            r_last;
  logic                            r_cfg_err;

  logic                            w_idle;
  logic                            w_accept;
  logic                            w_rev_in;
  logic                            w_illegal;
  logic                            w_load_beat;
  logic                            w_clear;
  logic [IN_LANES*DATA_WIDTH-1:0]  w_sel_data;
  logic [IDX_W-1:0]                w_sel_base;
  logic [IDX_W-1:0]                w_sel_end;
  logic [STRIDE_W-1:0]             w_sel_stride;
  logic [OUT_LANES*DATA_WIDTH-1:0] w_beat_data;
  logic [OUT_LANES-1:0]            w_beat_mask;
  logic                            w_beat_last;
  logic [IDX_W-1:0]                w_beat_next;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && valid_in;

`ifdef SLICE_REVERSE_EN
  logic r_rev;
  logic w_sel_rev;
  assign w_rev_in  = dir_rev;
  assign w_sel_rev = w_idle ? dir_rev : r_rev;
`else
  // Forward-only build: dir_rev is accepted on the port but never steers the walk.
  assign w_rev_in = dir_rev & 1'b0;
`endif

  assign w_illegal = (stride == '0) ||
                     (w_rev_in ? (start_idx < end_idx) : (start_idx > end_idx));

  // The first beat is built straight from the inputs so it lands the cycle after acceptance.
  assign w_sel_data   = w_idle ? data_in   : r_data;
  assign w_sel_base   = w_idle ? start_idx : r_next_base;
  assign w_sel_end    = w_idle ? end_idx   : r_end;
  assign w_sel_stride = w_idle ? stride    : r_stride;

  slice_lane_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_LANES   (IN_LANES),
    .OUT_LANES  (OUT_LANES),
    .STRIDE_W   (STRIDE_W),
    .IDX_W      (IDX_W)
  ) u_lane_select (
    .i_data      (w_sel_data),
    .i_base      (w_sel_base),
    .i_end       (w_sel_end),
    .i_stride    (w_sel_stride),
`ifdef SLICE_REVERSE_EN
    .i_rev       (w_sel_rev),
`endif
    .o_data      (w_beat_data),
    .o_mask      (w_beat_mask),
    .o_last      (w_beat_last),
    .o_next_base (w_beat_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_beat = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_illegal) begin
          w_state_nxt = ST_EMIT;
          w_load_beat = 1'b1;
        end
      end
      ST_EMIT: begin
        if (ready_out) begin
          if (r_last) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end else begin
            w_load_beat = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_end    <= '0;
      r_stride <= '0;
`ifdef SLICE_REVERSE_EN
      r_rev    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_data   <= data_in;
      r_end    <= end_idx;
      r_stride <= stride;
`ifdef SLICE_REVERSE_EN
      r_rev    <= dir_rev;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_mask      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_next_base <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && w_illegal;
      if (w_load_beat) begin
        r_data_out  <= w_beat_data;
        r_mask      <= w_beat_mask;
        r_valid     <= 1'b1;
        r_last      <= w_beat_last;
        r_next_base <= w_beat_next;
      end else if (w_clear) begin
        r_data_out <= '0;
        r_mask     <= '0;
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
      end
    end
  end

  assign ready_in  = w_idle;
  assign data_out  = r_data_out;
  assign lane_mask = r_mask;
  assign valid_out = r_valid;
  assign last_out  = r_last;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_strided_slice_unit.sv
// tb/tb_strided_slice_unit.sv - table-driven scoreboard bench for strided_slice_unit
module tb_strided_slice_unit;
  import npu_data_ops_pkg::*;

  localparam int DW = 16;
  localparam int IL = 64;
  localparam int OL = 16;
  localparam int SW = 4;
  localparam int IW = 6;

  logic              clk;
  logic              rst_n;
  logic [IL*DW-1:0]  data_in;
  logic              valid_in;
  logic              ready_in;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     end_idx;
  logic [SW-1:0]     stride;
  logic              dir_rev;
  logic [OL*DW-1:0]  data_out;
  logic [OL-1:0]     lane_mask;
  logic              valid_out;
  logic              last_out;
  logic              ready_out;
  logic              cfg_err;

  strided_slice_unit #(
    .DATA_WIDTH (DW),
    .IN_LANES   (IL),
    .OUT_LANES  (OL),
    .STRIDE_W   (SW),
    .IDX_W      (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .start_idx (start_idx),
    .end_idx   (end_idx),
    .stride    (stride),
    .dir_rev   (dir_rev),
    .data_out  (data_out),
    .lane_mask (lane_mask),
    .valid_out (valid_out),
    .last_out  (last_out),
    .ready_out (ready_out),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OL*DW-1:0] data;
    logic [OL-1:0]    mask;
    logic             last;
  } beat_t;

  typedef struct {
    slice_desc_t desc;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  beat_t            exp_q[$];
  beat_t            mon_e;
  vec_t             vt[12];
  logic [DW-1:0]    lanes[IL];
  int               checks = 0;
  int               errors = 0;
  int               beats_seen = 0;
  bit               rand_ready = 1'b0;
  logic [OL*DW-1:0] snap_data;
  logic [OL-1:0]    snap_mask;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference walk: step the index until it leaves [end, ...] and chunk into beats.
  function automatic int build(input int s, input int e, input int st, input bit rev);
    int    elem[$];
    int    idx;
    int    nb;
    beat_t b;
    idx = s;
    while (rev ? (idx >= e && idx >= 0) : (idx <= e)) begin
      elem.push_back(idx);
      idx = rev ? idx - st : idx + st;
    end
    nb = (elem.size() + OL - 1) / OL;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      b.mask = '0;
      b.last = (bi == nb - 1);
      for (int k = 0; k < OL; k++) begin
        if (bi * OL + k < elem.size()) begin
          b.data[k*DW +: DW] = lanes[elem[bi*OL + k]];
          b.mask[k] = 1'b1;
        end
      end
      exp_q.push_back(b);
    end
    return nb;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", lane_mask);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", 256'(data_out), 256'(mon_e.data));
        check("beat_mask", 256'(lane_mask), 256'(mon_e.mask));
        check("beat_last", 256'(last_out), 256'(mon_e.last));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready_out = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic apply(input slice_desc_t d, input bit exp_err, input int exp_beats, input int hold);
    int k;
    bit rev_eff;
`ifdef SLICE_REVERSE_EN
    rev_eff = d.rev;
`else
    rev_eff = 1'b0;
`endif
    @(negedge clk);
    for (k = 0; k < 100 && !ready_in; k++) @(negedge clk);
    check("ready_wait", 256'(ready_in), 256'(1));
    for (int i = 0; i < IL; i++) begin
      lanes[i] = 16'($urandom);
      data_in[i*DW +: DW] = lanes[i];
    end
    start_idx = d.start_idx[IW-1:0];
    end_idx   = d.end_idx[IW-1:0];
    stride    = d.stride[SW-1:0];
    dir_rev   = d.rev;
    valid_in  = 1'b1;
    if (!exp_err) void'(build(int'(d.start_idx), int'(d.end_idx), int'(d.stride), rev_eff));
    beats_seen = 0;
    if (hold > 0) begin
      rand_ready = 1'b0;
      ready_out  = 1'b0;
    end
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    data_in   = {32{32'($urandom)}};
    start_idx = 6'($urandom);
    end_idx   = 6'($urandom);
    stride    = 4'($urandom);
    @(negedge clk);
    if (exp_err) begin
      check("err_pulse", 256'(cfg_err), 256'(1));
      check("err_no_valid", 256'(valid_out), 256'(0));
      check("err_ready_in", 256'(ready_in), 256'(1));
      @(negedge clk);
      check("err_pulse_end", 256'(cfg_err), 256'(0));
      check("err_no_valid2", 256'(valid_out), 256'(0));
    end else begin
      check("first_valid_latency", 256'(valid_out), 256'(1));
      check("busy_ready_in", 256'(ready_in), 256'(0));
      check("no_err", 256'(cfg_err), 256'(0));
      if (hold > 0) begin
        snap_data = data_out;
        snap_mask = lane_mask;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_stable", {valid_out, last_out, lane_mask, data_out[222:0]},
                {1'b1, exp_q[0].last, snap_mask, snap_data[222:0]});
        end
        @(posedge clk);
        #1;
        ready_out  = 1'b1;
        rand_ready = 1'b1;
      end
      for (k = 0; k < 300 && !(exp_q.size() == 0 && ready_in && !valid_out); k++) @(negedge clk);
      check("slice_done", 256'(exp_q.size() == 0 && ready_in && !valid_out), 256'(1));
    end
    check("beat_count", 256'(beats_seen), 256'(exp_beats));
  endtask

  function automatic slice_desc_t mk(input int s, input int e, input int st, input bit rev);
    slice_desc_t d;
    d.start_idx = 16'(s);
    d.end_idx   = 16'(e);
    d.stride    = 8'(st);
    d.rev       = rev;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; start_idx = '0; end_idx = '0;
    stride = '0; dir_rev = 1'b0; ready_out = 1'b1;

    vt[0]  = '{mk(4, 19, 1, 0),   1'b0, 1};
    vt[1]  = '{mk(0, 63, 2, 0),   1'b0, 2};
    vt[2]  = '{mk(10, 30, 3, 0),  1'b0, 1};
    vt[3]  = '{mk(8, 40, 0, 0),   1'b1, 0};
    vt[4]  = '{mk(20, 5, 1, 0),   1'b1, 0};
    vt[6]  = '{mk(63, 63, 15, 0), 1'b0, 1};
    vt[7]  = '{mk(0, 63, 1, 0),   1'b0, 4};
    vt[8]  = '{mk(0, 63, 15, 0),  1'b0, 1};
    vt[9]  = '{mk(0, 0, 1, 1),    1'b0, 1};
    vt[10] = '{mk(1, 63, 4, 0),   1'b0, 1};
`ifdef SLICE_REVERSE_EN
    vt[5]  = '{mk(40, 0, 5, 1),   1'b0, 1};
    vt[11] = '{mk(63, 0, 4, 1),   1'b0, 1};
`else
    vt[5]  = '{mk(40, 0, 5, 1),   1'b1, 0};
    vt[11] = '{mk(63, 0, 4, 1),   1'b1, 0};
`endif

    repeat (3) @(negedge clk);
    check("rst_ready_in", 256'(ready_in), 256'(1));
    check("rst_valid_out", 256'(valid_out), 256'(0));
    check("rst_outputs", {lane_mask, last_out, cfg_err, data_out[221:0]}, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready_in", 256'(ready_in), 256'(1));

    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) apply(vt[i].desc, vt[i].exp_err, vt[i].exp_beats, 0);

    apply(mk(10, 30, 3, 0), 1'b0, 1, 5);
    check("bp_mask", 256'(snap_mask), 256'(16'h007F));
    check("bp_upper_zero", 256'(snap_data[OL*DW-1:7*DW]), 256'(0));
    check("bp_lane0", 256'(snap_data[DW-1:0]), 256'(lanes[10]));
    check("bp_lane6", 256'(snap_data[6*DW +: DW]), 256'(lanes[28]));

    rand_ready = 1'b0;
    ready_out  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < IL; i++) data_in[i*DW +: DW] = 16'(i);
    start_idx = 6'd0; end_idx = 6'd63; stride = 4'd2; dir_rev = 1'b0; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    check("mid_valid_before_rst", 256'(valid_out), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_out", 256'(valid_out), 256'(0));
    check("mid_rst_ready_in", 256'(ready_in), 256'(1));
    check("mid_rst_outputs", {lane_mask, last_out, data_out[238:0]}, 256'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_out  = 1'b1;
    rand_ready = 1'b1;
    apply(mk(0, 63, 2, 0), 1'b0, 2, 0);
    apply(mk(40, 0, 5, 0), 1'b1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strided_slice_unit.md
Name: strided_slice_unit

Overview:
- Parametrised successor to the single-shot slice stage in the data_ops path.
- Captures one IN_LANES-wide vector together with a slice descriptor (start, end, stride).
- Streams the selected elements out as one or more OUT_LANES-wide beats, with a per-lane valid mask and a last flag.
- Sits between the vector buffer read port and downstream reshape/concat units.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- IN_LANES, 64, elements per input vector (power of 2).
- OUT_LANES, 16, elements per output beat (power of 2, ≤ IN_LANES).
- STRIDE_W, 4, stride field width.
- IDX_W, $clog2(IN_LANES), index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  IN_LANES*DATA_WIDTH  flattened input vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  1  input vector/descriptor valid.
- ready_in  out  1  unit can accept a vector.
- start_idx  in  IDX_W  first element index.
- end_idx  in  IDX_W  last permitted element index (inclusive).
- stride  in  STRIDE_W  element step.
- dir_rev  in  1  reverse walk (effective only with the optional feature).
- data_out  out  OUT_LANES*DATA_WIDTH  flattened output beat.
- lane_mask  out  OUT_LANES  per-lane valid.
- valid_out  out  1  beat valid.
- last_out  out  1  final beat of the slice.
- ready_out  in  1  downstream accepts the beat.
- cfg_err  out  1  one-cycle pulse on an illegal descriptor.

Behaviour:
- Reset (async): data_out=0, lane_mask=0, valid_out=0, last_out=0, cfg_err=0, ready_in=1, state=IDLE. Reset mid-slice abandons the slice; no partial beat survives.
- States: IDLE, EMIT.
- IDLE:
  - ready_in=1.
  - On valid_in&&ready_in, register data_in, start_idx, end_idx, stride, dir_rev.
  - Illegal descriptor: stride==0, or start_idx>end_idx (forward), or start_idx<end_idx (reverse). Then pulse cfg_err next cycle, emit no beat, stay IDLE.
  - Otherwise base←start_idx, go EMIT.
- EMIT:
  - ready_in=0.
  - Lane j index = base + j*stride (forward) or base − j*stride (reverse).
  - Compute in IDX_W+$clog2(OUT_LANES)+STRIDE_W+1 bits, signed for reverse, so no wrap.
  - Lane valid iff index ≤ end_idx (forward) or index ≥ end_idx and ≥ 0 (reverse).
  - Valid lane carries the captured element; invalid lane outputs 0 and its mask bit is 0.
  - Beat outputs are registered. First valid_out occurs exactly 1 cycle after input acceptance.
  - last_out=1 when the next base (base ± OUT_LANES*stride) falls past end_idx.
  - valid_out, data_out, lane_mask and last_out hold stable while ready_out=0.
  - On valid_out&&ready_out: if last_out, go IDLE; otherwise advance base and present the next beat the following cycle. Throughput is 1 beat/cycle under continuous ready_out.
- Element count: (|end−start|)/stride+1, never computed by division. Mask bits are always contiguous from lane 0.
- ready_in returns to 1 the cycle after the last beat is accepted. There is no overlap of input capture with EMIT.
- Descriptor inputs are sampled only at acceptance; changes during EMIT are ignored.

Optional Feature:
- Macro: SLICE_REVERSE_EN.
- Defined: dir_rev honoured as described above.
- Undefined: dir_rev ignored (treated as 0), reverse datapath not built, and start_idx>end_idx always raises cfg_err.

Decomposition:
- Shared package npu_data_ops_pkg holds:
  - state encoding constants ST_IDLE/ST_EMIT;
  - a descriptor struct/typedef (start, end, stride, rev);
  - the index-width function.
- One natural sub-module, slice_lane_select: combinational per-beat index generation, mask and mux (OUT_LANES instances of an IN_LANES:1 mux). The top level keeps the FSM, capture registers and output registers.

Test Plan:
- Contiguous slice: start=4, end=19, stride=1, data_in[i]=i → one beat, lanes 4..19, mask=16'hFFFF, last_out=1, valid_out 1 cycle after accept.
- Strided multi-beat: start=0, end=63, stride=2 → 2 beats: elements 0,2..30 then 32..62, both masks FFFF, last_out only on beat 2.
- Partial beat with backpressure: start=10, end=30, stride=3 (7 elements 10..28), ready_out=0 for 5 cycles → mask=16'h007F, outputs held stable, lanes 7..15 = 0.
- Illegal descriptors: stride=0, then start=20/end=5 forward → cfg_err one-cycle pulse each, no valid_out, ready_in stays 1.
- Reverse (SLICE_REVERSE_EN): start=40, end=0, stride=5, rev=1 → one beat 40,35..0, mask=16'h01FF. Without the macro, the same stimulus raises cfg_err.
- Reset asserted mid-EMIT of a 2-beat slice → valid_out=0 and ready_in=1 immediately; next slice after release is correct.
